// File: rtl/grid_led_pairs.sv
// -----------------------------------------------------------------------------
// grid_led_pairs
//
// LED-grid driver for a card-matching game. The block takes card picks one at
// a time, lights each picked card, and compares the symbols of each pair.
// Matched pairs stay lit for good. A mismatched pair stays lit for a hold window
// and is then turned off. When every location is matched, all_found rises and
// the block stops accepting picks until reset.
//
// Parameters
//   ROWS, COLS   grid size; N = ROWS*COLS must be even
//   SYMW         card symbol width
//   HOLD_CYCLES  cycles a mismatched pair stays lit (>= 1)
//   BLINK_LOG2   blink half-period = 2**BLINK_LOG2 cycles (blink build only)
//
// Ports (IDXW = $clog2(N))
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pick_valid   in   pick request
//   pick_ready   out  block can accept a pick (decoded from state)
//   pick_loc     in   [IDXW] grid index, row*COLS+col
//   pick_sym     in   [SYMW] symbol stored at pick_loc
//   leds         out  [N] LED drive, bit i = location i
//   found        out  [N] matched locations
//   match_pulse  out  one-cycle pulse per matched pair
//   miss_pulse   out  one-cycle pulse when a mismatched pair is hidden
//   pick_err     out  one-cycle pulse per rejected pick
//   all_found    out  every location matched
//
// Build option
//   GRID_LED_PAIRS_BLINK_EN  when defined, the mismatched pair blinks during
//                            the hold window. The found LEDs stay steady.
// -----------------------------------------------------------------------------
module grid_led_pairs #(
  parameter  int ROWS        = 6,
  parameter  int COLS        = 6,
  parameter  int SYMW        = 5,
  parameter  int HOLD_CYCLES = 50_000_000,
  parameter  int BLINK_LOG2  = 22,
  localparam int N           = ROWS * COLS,
  localparam int IDXW        = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            pick_valid,
  output logic            pick_ready,
  input  logic [IDXW-1:0] pick_loc,
  input  logic [SYMW-1:0] pick_sym,
  output logic [N-1:0]    leds,
  output logic [N-1:0]    found,
  output logic            match_pulse,
  output logic            miss_pulse,
  output logic            pick_err,
  output logic            all_found
);

  localparam int              CNTW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDXW:0]   LOC_LIMIT = (IDXW + 1)'(N);
  localparam logic [CNTW-1:0] HOLD_LOAD = CNTW'(HOLD_CYCLES - 1);

  if ((N % 2) != 0) begin : g_odd_grid
    $error("grid_led_pairs: ROWS*COLS must be even");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("grid_led_pairs: HOLD_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,  // no card face-up
    S_ONE,   // first card face-up
    S_HOLD,  // mismatched pair face-up
    S_DONE   // every location matched
  } state_t;

  state_t          state, state_n;
  logic [IDXW-1:0] loc1, loc1_n, loc2, loc2_n;
  logic [SYMW-1:0] sym1, sym1_n;
  logic [CNTW-1:0] hold_cnt, hold_cnt_n;
  logic [N-1:0]    faceup, faceup_n, found_n, leds_n;
  logic            match_n, miss_n, err_n;
  logic            fire, in_range, bad_pick, show_faceup;
  logic [N-1:0]    pick_bit, loc1_bit, loc2_bit;

  assign pick_ready = (state == S_IDLE) || (state == S_ONE);
  assign fire       = pick_valid && pick_ready;

  // An out-of-range index gets no one-hot bit. This keeps found checks and
  // face-up writes from touching a location that does not exist.
  assign in_range = {1'b0, pick_loc} < LOC_LIMIT;
  assign pick_bit = in_range ? (N'(1) << pick_loc) : '0;
  assign loc1_bit = N'(1) << loc1;
  assign loc2_bit = N'(1) << loc2;

  assign bad_pick = !in_range || ((found & pick_bit) != '0) ||
                    ((state == S_ONE) && (pick_loc == loc1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    state_n    = state;
    loc1_n     = loc1;
    loc2_n     = loc2;
    sym1_n     = sym1;
    hold_cnt_n = hold_cnt;
    faceup_n   = faceup;
    found_n    = found;
    match_n    = 1'b0;
    miss_n     = 1'b0;
    err_n      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (fire) begin
          if (bad_pick) begin
            err_n = 1'b1;
          end else begin
            loc1_n   = pick_loc;
            sym1_n   = pick_sym;
            faceup_n = faceup | pick_bit;
            state_n  = S_ONE;
          end
        end
      end

      S_ONE: begin
        if (fire) begin
          if (bad_pick) begin
            err_n = 1'b1;
          end else if (pick_sym == sym1) begin
            found_n  = found | loc1_bit | pick_bit;
            faceup_n = faceup & ~loc1_bit;
            match_n  = 1'b1;
            state_n  = (&found_n) ? S_DONE : S_IDLE;
          end else begin
            loc2_n     = pick_loc;
            faceup_n   = faceup | pick_bit;
            hold_cnt_n = HOLD_LOAD;
            state_n    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (hold_cnt == '0) begin
          faceup_n = faceup & ~(loc1_bit | loc2_bit);
          miss_n   = 1'b1;
          state_n  = S_IDLE;
        end else begin
          hold_cnt_n = hold_cnt - 1'b1;
        end
      end

      S_DONE: ;

      default: state_n = S_IDLE;
    endcase
  end

`ifdef GRID_LED_PAIRS_BLINK_EN
  logic [BLINK_LOG2:0] blink_cnt, blink_n;

  // The counter runs freely and restarts on HOLD entry, so every hold window
  // begins in the "on" phase. The phase bit is taken from the next count
  // because leds is registered on the same edge.
  always_comb begin
    blink_n = blink_cnt + 1'b1;
    if ((state == S_ONE) && (state_n == S_HOLD)) blink_n = '0;
  end

  assign show_faceup = !((state_n == S_HOLD) && blink_n[BLINK_LOG2]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) blink_cnt <= '0;
    else          blink_cnt <= blink_n;
  end
`else
  assign show_faceup = 1'b1;
`endif

  assign leds_n = found_n | (show_faceup ? faceup_n : '0);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values. Every register is reset because the whole game
  // restarts on reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      loc1        <= '0;
      loc2        <= '0;
      sym1        <= '0;
      hold_cnt    <= '0;
      faceup      <= '0;
      found       <= '0;
      leds        <= '0;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      pick_err    <= 1'b0;
      all_found   <= 1'b0;
    end else begin
      state       <= state_n;
      loc1        <= loc1_n;
      loc2        <= loc2_n;
      sym1        <= sym1_n;
      hold_cnt    <= hold_cnt_n;
      faceup      <= faceup_n;
      found       <= found_n;
      leds        <= leds_n;
      match_pulse <= match_n;
      miss_pulse  <= miss_n;
      pick_err    <= err_n;
      all_found   <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_grid_led_pairs.sv
// -----------------------------------------------------------------------------
// tb_grid_led_pairs
//
// Drives a 2x2 grid (HOLD_CYCLES=4, BLINK_LOG2=1) through directed game
// scenarios, then through a random pick stream. Each output is compared with a
// game-level reference model. A second 3x2 instance covers pick indices beyond
// the grid, which the 2-bit index of a 2x2 grid cannot express.
// -----------------------------------------------------------------------------
module tb_grid_led_pairs;

  localparam int N          = 4;
  localparam int IDXW       = 2;
  localparam int SYMW       = 5;
  localparam int HOLD       = 4;
  localparam int BLINK_LOG2 = 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic            pick_valid = 1'b0;
  logic [IDXW-1:0] pick_loc = '0;
  logic [SYMW-1:0] pick_sym = '0;
  logic            pick_ready, match_pulse, miss_pulse, pick_err, all_found;
  logic [N-1:0]    leds, found;

  logic            b_valid = 1'b0;
  logic [2:0]      b_loc = '0;
  logic [SYMW-1:0] b_sym = '0;
  logic            b_ready, b_match, b_miss, b_err, b_all;
  logic [5:0]      b_leds, b_found;

  grid_led_pairs #(.ROWS(2), .COLS(2), .SYMW(SYMW), .HOLD_CYCLES(HOLD),
                   .BLINK_LOG2(BLINK_LOG2)) dut (
    .clock(clock), .reset_n(reset_n), .pick_valid(pick_valid),
    .pick_ready(pick_ready), .pick_loc(pick_loc), .pick_sym(pick_sym),
    .leds(leds), .found(found), .match_pulse(match_pulse),
    .miss_pulse(miss_pulse), .pick_err(pick_err), .all_found(all_found)
  );

  grid_led_pairs #(.ROWS(3), .COLS(2), .SYMW(SYMW), .HOLD_CYCLES(HOLD),
                   .BLINK_LOG2(BLINK_LOG2)) dut_b (
    .clock(clock), .reset_n(reset_n), .pick_valid(b_valid),
    .pick_ready(b_ready), .pick_loc(b_loc), .pick_sym(b_sym),
    .leds(b_leds), .found(b_found), .match_pulse(b_match),
    .miss_pulse(b_miss), .pick_err(b_err), .all_found(b_all)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a record of the game in terms of cards, not hardware.
  bit              found_m[N];
  int              up[$];       // locations currently face-up, in pick order
  int              sym1_m;
  int              hold_left;   // cycles of mismatch display still to come
  bit              e_match, e_miss, e_err;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit game_done();
    bit d;
    d = 1'b1;
    for (int i = 0; i < N; i++) if (!found_m[i]) d = 1'b0;
    return d;
  endfunction

  function automatic logic [N-1:0] exp_leds();
    logic [N-1:0] v;
    bit visible;
    v = '0;
    visible = 1'b1;
    for (int i = 0; i < N; i++) if (found_m[i]) v[i] = 1'b1;
`ifdef GRID_LED_PAIRS_BLINK_EN
    if (hold_left > 0 && (((HOLD - hold_left) >> BLINK_LOG2) % 2 == 1)) visible = 1'b0;
`endif
    if (visible) foreach (up[k]) v[up[k]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) found_m[i] = 1'b0;
    up.delete();
    hold_left = 0;
    sym1_m    = 0;
    e_match   = 1'b0;
    e_miss    = 1'b0;
    e_err     = 1'b0;
  endtask

  // Applies what one rising edge does to the game, given the inputs at the edge.
  task automatic model_edge(input bit v, input int loc, input int sym);
    bit bad;
    e_match = 1'b0;
    e_miss  = 1'b0;
    e_err   = 1'b0;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) begin
        up.delete();
        e_miss = 1'b1;
      end
    end else if (!game_done() && v) begin
      bad = (loc >= N) || found_m[loc] || (up.size() == 1 && up[0] == loc);
      if (bad) begin
        e_err = 1'b1;
      end else if (up.size() == 0) begin
        up.push_back(loc);
        sym1_m = sym;
      end else if (sym == sym1_m) begin
        found_m[up[0]] = 1'b1;
        found_m[loc]   = 1'b1;
        up.delete();
        e_match = 1'b1;
      end else begin
        up.push_back(loc);
        hold_left = HOLD;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i] = found_m[i];
    check("leds", leds, exp_leds());
    check("found", found, f);
    check("match_pulse", match_pulse, e_match);
    check("miss_pulse", miss_pulse, e_miss);
    check("pick_err", pick_err, e_err);
    check("all_found", all_found, game_done());
    check("pick_ready", pick_ready, !(hold_left > 0 || game_done()));
  endtask

  task automatic cycle(input bit v, input int loc, input int sym);
    pick_valid = v;
    pick_loc   = IDXW'(loc);
    pick_sym   = SYMW'(sym);
    @(posedge clock);
    model_edge(v, loc, sym);
    #1;
    compare_all();
  endtask

  // Reset is asserted between edges, so the cleared outputs are checked before
  // any clock edge can produce them.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // Out-of-range picks on the 3x2 instance (N=6, 3-bit index).
    b_valid = 1'b1; b_loc = 3'd7; b_sym = 5'd1;
    @(posedge clock); #1;
    check("b_err_loc7", b_err, 1'b1);
    check("b_leds_loc7", b_leds, 6'b000000);
    b_loc = 3'd6;
    @(posedge clock); #1;
    check("b_err_loc6", b_err, 1'b1);
    check("b_ready_after_err", b_ready, 1'b1);
    b_loc = 3'd5;
    @(posedge clock); #1;
    check("b_err_loc5", b_err, 1'b0);
    check("b_leds_loc5", b_leds, 6'b100000);
    b_valid = 1'b0;
    do_reset();

    // Mismatch 1/3 with pick_valid held high during the hold window.
    cycle(1, 1, 2);
    cycle(1, 3, 7);
    check("miss_entry_leds", leds, 4'b1010);
    check("miss_entry_ready", pick_ready, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      cycle(1, 0, 1);
`ifndef GRID_LED_PAIRS_BLINK_EN
      if (i < HOLD - 1) check("miss_hold_leds", leds, 4'b1010);
`endif
      check("miss_hold_no_err", pick_err, 1'b0);
    end
    check("miss_exit_leds", leds, 4'b0000);
    check("miss_exit_pulse", miss_pulse, 1'b1);
    check("miss_exit_ready", pick_ready, 1'b1);
    do_reset();

    // Match 0/2, rejected picks, then the final match.
    cycle(1, 0, 3);
    check("first_pick_leds", leds, 4'b0001);
    cycle(1, 2, 3);
    check("match_leds", leds, 4'b0101);
    check("match_pulse_hi", match_pulse, 1'b1);
    check("match_ready", pick_ready, 1'b1);
    cycle(0, 0, 0);
    check("match_pulse_lo", match_pulse, 1'b0);
    cycle(1, 0, 3);
    check("found_pick_err", pick_err, 1'b1);
    cycle(1, 1, 2);
    cycle(1, 1, 2);
    check("same_loc_err", pick_err, 1'b1);
    check("same_loc_leds", leds, 4'b0111);
    cycle(1, 3, 2);
    check("all_found", all_found, 1'b1);
    check("all_leds", leds, 4'b1111);
    check("done_ready", pick_ready, 1'b0);
    cycle(1, 1, 5);
    check("done_ignore_err", pick_err, 1'b0);
    do_reset();

    // Reset in the second cycle of HOLD, with a found pair on the board.
    cycle(1, 0, 3);
    cycle(1, 2, 3);
    cycle(1, 1, 2);
    cycle(1, 3, 7);
    cycle(0, 0, 0);
    do_reset();
    check("post_reset_ready", pick_ready, 1'b1);
    check("post_reset_found", found, 4'b0000);

    // Random pick stream; the small symbol range makes matches frequent.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0 || (game_done() && $urandom_range(0, 3) == 0))
        do_reset();
      else
        cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
